// File: rtl/pio_mem_write_bridge.sv
// Turns each rising edge of a software-driven wren level into one Avalon-MM write.
// Tracks wait-request stalls with an optional timeout and keeps sticky done/overrun/timeout flags.
module pio_mem_write_bridge #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_status,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              timeout,
  output logic [3:0]        status
);

  localparam int unsigned TIMER_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic                wren_q_reg;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                done_reg, done_next;
  logic                overrun_reg, overrun_next;
  logic                timeout_reg, timeout_next;
  logic                rise;

  assign rise = wren & ~wren_q_reg;

  // wren_q resets high so a level already asserted at reset release is not seen as an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      wren_q_reg  <= 1'b1;
      addr_reg    <= '0;
      data_reg    <= '0;
      timer_reg   <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wren_q_reg  <= wren;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      timer_reg   <= timer_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    timer_next   = timer_reg;
    done_next    = done_reg;
    overrun_next = overrun_reg;
    timeout_next = timeout_reg;

    // Clear first so that any set below takes priority in the same cycle
    if (clr_status) begin
      done_next    = 1'b0;
      overrun_next = 1'b0;
      timeout_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (rise) begin
          addr_next    = wr_addr;
          data_next    = wr_data;
          timer_next   = '0;
          done_next    = 1'b0;
          timeout_next = 1'b0;
          state_next   = WRITE;
        end
      end
      WRITE: begin
        if (rise) begin
          overrun_next = 1'b1;
        end
        if (!mem_waitrequest) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          if (timer_reg != TIMER_MAX) begin
            timer_next = timer_reg + TIMER_W'(1);
          end
          if ((TIMEOUT != 0) && (timer_reg == TIMER_LAST)) begin
            timeout_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_write     = (state_reg == WRITE);
  assign busy          = (state_reg == WRITE);
  assign mem_address   = addr_reg;
  assign mem_writedata = data_reg;
  assign done          = done_reg;
  assign overrun       = overrun_reg;
  assign timeout       = timeout_reg;
  assign status        = {timeout_reg, overrun_reg, done_reg, busy};

endmodule

// File: tb/tb_pio_mem_write_bridge.sv
// Scoreboard bench for pio_mem_write_bridge: each write is predicted at transaction level
// (address, data, pulse length, outcome, overrun) and checked by an independent monitor.
module tb_pio_mem_write_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wren;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_status;
  logic [9:0]  mem_address;
  logic [31:0] mem_writedata;
  logic        mem_write;
  logic        mem_waitrequest;
  logic        busy, done, overrun, timeout;
  logic [3:0]  status;

  pio_mem_write_bridge #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_status(clr_status), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_waitrequest(mem_waitrequest), .busy(busy), .done(done),
    .overrun(overrun), .timeout(timeout), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    int          len;
    bit          to;
    bit          ovr;
  } exp_t;

  exp_t sc_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   stall_k = 0;
  bit   ovr_model = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave responder: stall the first stall_k edges of every write, random when idle
  initial begin
    int seen = 0;
    mem_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) begin
        mem_waitrequest = (seen < stall_k);
        seen++;
      end else begin
        mem_waitrequest = 1'($urandom_range(0, 1));
        seen = 0;
      end
    end
  end

  // Monitor: follows mem_write pulses and compares them with the predicted transactions
  initial begin
    bit   active = 0;
    bit   bogus  = 0;
    int   len    = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (reset) begin
        sc_q.delete();
        active = 0;
        bogus  = 0;
      end else if (mem_write && !active) begin
        active = 1;
        len    = 1;
        if (sc_q.size() == 0) begin
          bogus = 1;
          check("unexpected_write", 1, 0);
        end else begin
          cur = sc_q[0];
          check("start_addr", mem_address, cur.a);
          check("start_data", mem_writedata, cur.d);
          check("start_busy", busy, 1);
          check("start_done_cleared", done, 0);
          check("start_timeout_cleared", timeout, 0);
        end
      end else if (mem_write && active) begin
        len++;
        if (!bogus) begin
          check("hold_addr", mem_address, cur.a);
          check("hold_data", mem_writedata, cur.d);
        end
      end else if (!mem_write && active) begin
        active = 0;
        if (bogus) begin
          bogus = 0;
        end else begin
          void'(sc_q.pop_front());
          check("pulse_len", len, cur.len);
          check("end_done", done, !cur.to);
          check("end_timeout", timeout, cur.to);
          check("end_overrun", overrun, cur.ovr);
          check("end_busy", busy, 0);
          check("end_status", status, {cur.to, cur.ovr, !cur.to, 1'b0});
          check("end_addr_kept", mem_address, cur.a);
        end
      end
    end
  end

  // One write: k stalled edges, optional extra rise during the write, optional clear on completion edge
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int k,
                          input bit extra_in, input bit clr_prio);
    exp_t e;
    int   n;
    bit   extra;
    e.a   = a;
    e.d   = d;
    e.to  = (k >= TO);
    e.len = e.to ? TO : k + 1;
    extra = extra_in && (e.len >= 2) && !clr_prio;
    if (extra) ovr_model = 1;
    if (clr_prio) ovr_model = 0;
    e.ovr = ovr_model;
    sc_q.push_back(e);
    stall_k = k;
    @(negedge clk);
    wren = 1'b0; wr_addr = a; wr_data = d; clr_status = 1'b0;
    @(negedge clk);
    wren = 1'b1;
    @(negedge clk);
    if (clr_prio) clr_status = 1'b1;
    if (extra) begin
      wren = 1'b0;
      wr_addr = 10'($urandom);
      wr_data = $urandom;
      @(negedge clk);
      wren = 1'b1;
    end
    n = 0;
    while (mem_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("write_end_timeout_budget", n, 0);
    if (clr_prio) begin
      @(negedge clk);
      clr_status = 1'b0;
      check("clr_after_done", done, 0);
      check("clr_after_status", status, 0);
    end
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    ovr_model = 0;
    check("clr_status_word", status, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wren = 1'b0; wr_addr = '0; wr_data = '0; clr_status = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_mem_write", mem_write, 0);
    check("reset_status", status, 0);
    check("reset_addr", mem_address, 0);
    check("reset_data", mem_writedata, 0);
    reset = 1'b0;

    do_write(10'h12A, 32'hDEADBEEF, 0, 0, 0);
    do_write(10'h055, 32'h01234567, 3, 0, 0);
    do_write(10'h3F0, 32'hCAFEF00D, 3, 1, 0);
    pulse_clr();
    do_write(10'h001, 32'h0BADBEEF, 30, 0, 0);
    do_write(10'h002, 32'h11112222, TO - 1, 0, 0);
    do_write(10'h003, 32'h33334444, 0, 0, 1);

    // Reset in the middle of a stalled write, with wren held high through release
    do_write_reset_case();

    do_write(10'h004, 32'h55556666, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_write(10'($urandom), $urandom, int'($urandom_range(0, 12)),
               1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  task automatic do_write_reset_case();
    exp_t e;
    e.a = 10'h2AA; e.d = 32'hA5A5A5A5; e.len = 0; e.to = 0; e.ovr = ovr_model;
    sc_q.push_back(e);
    stall_k = 100;
    @(negedge clk);
    wren = 1'b0; wr_addr = e.a; wr_data = e.d;
    @(negedge clk);
    wren = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_mem_write", mem_write, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_mem_write", mem_write, 0);
    check("async_reset_status", status, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ovr_model = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_write_wren_held", mem_write, 0);
    end
    wren = 1'b0;
  endtask

endmodule

// File: doc/pio_mem_write_bridge.md
Name: pio_mem_write_bridge

Overview:
- Consumes the 1-bit software-driven write-enable level from the `wren` output PIO, together with the address and data PIOs. Turns each rising edge into exactly one Avalon-MM master write on a downstream memory port.
- Reports progress back to software through a 4-bit status word, which is wired to an input PIO.
- Adds wait-request handling, a timeout abort, and sticky done/overrun/timeout flags, so software polls instead of relying on fixed delays.

Parameters:
- ADDR_W, 10, width of wr_addr / mem_address.
- DATA_W, 32, width of wr_data / mem_writedata.
- TIMEOUT, 255, maximum cycles mem_write may stay stalled by mem_waitrequest. Range 0..65535; 0 disables the timeout.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- wren  in  1  write-enable level from the wren PIO out_port.
- wr_addr  in  ADDR_W  target address from the address PIO.
- wr_data  in  DATA_W  write data from the data PIO.
- clr_status  in  1  single-cycle pulse; clears done, overrun and timeout.
- mem_address  out  ADDR_W  Avalon master address.
- mem_writedata  out  DATA_W  Avalon master write data.
- mem_write  out  1  Avalon master write strobe.
- mem_waitrequest  in  1  Avalon slave stall.
- busy  out  1  high while a write is outstanding.
- done  out  1  sticky: last accepted write completed.
- overrun  out  1  sticky: a rising edge arrived while busy and was dropped.
- timeout  out  1  sticky: last write aborted on timeout.
- status  out  4  {timeout, overrun, done, busy}, for the readback PIO.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timer 0, wren_q = 1.
  - wren_q resets to 1 so that a wren held high across reset release does not trigger a write.
- Edge detect: wren_q <= wren every cycle; rise = wren & ~wren_q. There is no synchronizer; wren is same-clock.
- FSM states: IDLE, WRITE.
- IDLE, on rise:
  - Capture wr_addr -> mem_address and wr_data -> mem_writedata.
  - Set mem_write=1 and busy=1; clear done and timeout; timer <= 0; go to WRITE.
  - mem_write is asserted the cycle after the edge where wren is first sampled high.
- WRITE, normal completion:
  - mem_address and mem_writedata are held stable.
  - At the first edge with mem_write=1 and mem_waitrequest=0, the transfer completes: mem_write<=0, busy<=0, done<=1, go to IDLE.
  - Minimum mem_write pulse is 1 cycle.
- WRITE, stall:
  - Each edge with mem_waitrequest=1 increments the timer.
  - If TIMEOUT!=0 and the timer equals TIMEOUT-1 at an edge with mem_waitrequest=1, the write is aborted: mem_write<=0, busy<=0, timeout<=1, done stays 0, go to IDLE.
  - mem_write is therefore high for exactly TIMEOUT cycles on a timeout.
  - Timer width is clog2(TIMEOUT+1), minimum 1; the timer saturates and never wraps.
- Overrun:
  - A rise while in WRITE, including the completing/aborting edge, sets overrun.
  - That request is dropped; the captured address and data are unchanged.
  - A rise in IDLE in the cycle immediately after completion is accepted normally.
- Address/data after completion: mem_address and mem_writedata keep their last values after completion or abort.
- clr_status:
  - Clears done, overrun and timeout.
  - If a set condition for a flag occurs in the same cycle, the set wins for that flag.
  - clr_status does not affect busy, the FSM or an in-flight write.
- Status word: status is a pure concatenation of the registered flags; it has no extra latency.
- Reset mid-write: mem_write drops immediately (asynchronously), all flags clear, and the in-flight write is abandoned.
- wren falling: no action; only rising edges matter.

Test Plan:
- Write with slave never stalling: wr_addr=0x12A, wr_data=0xDEADBEEF, mem_waitrequest=0, wren 0->1 -> mem_write high exactly 1 cycle, starting 1 cycle after wren is sampled high, with mem_address=0x12A and mem_writedata=0xDEADBEEF; then busy=0, done=1, status=4'b0010.
- Stalled write: mem_waitrequest=1 for 3 cycles, then 0 -> mem_write high 4 cycles with address/data stable; done=1 after the 4th edge; timeout=0.
- Overrun: pulse wren 0->1->0->1 while waitrequest=1 -> overrun=1; only the first address/data is issued; after completion status=4'b0110. Then clr_status -> status=4'b0000.
- Timeout: TIMEOUT=8, mem_waitrequest stuck at 1 -> mem_write high exactly 8 cycles, then 0; timeout=1, done=0, busy=0. Next rise clears timeout and starts a new write.
- Set/clear priority: assert clr_status on the edge where a write completes -> done=1 (set wins). Assert clr_status on the following edge -> done=0.
- Reset behaviour: assert reset during WRITE -> mem_write=0 and status=0 immediately. Keep wren=1 through reset release -> no write issued until wren goes 0 then 1.
